// File: rtl/doodle_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doodle_pkg : state encodings and default geometry for doodle_jump_ctrl
// Revision   : 1.0
// ---------------------------------------------------------------------------
package doodle_pkg;

   typedef enum logic [3:0] {
      ST_I    = 4'b0001,
      ST_UP   = 4'b0010,
      ST_DOWN = 4'b0100,
      ST_DONE = 4'b1000
   } state_t;

   localparam int DEF_NUM_PLAT = 6;
   localparam int DEF_COORD_W  = 10;
   localparam int DEF_SCORE_W  = 16;
   localparam int DEF_DOODLE_R = 10;
   localparam int DEF_PLAT_W   = 64;
   localparam int DEF_PLAT_H   = 16;
   localparam int DEF_FLOOR_Y  = 515;
   localparam int DEF_V_MIDDLE = 275;

endpackage
`default_nettype wire

// File: rtl/doodle_plat_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doodle_plat_scan : one-platform-per-cycle landing scan with hit comparator
// Revision         : 1.0
// ---------------------------------------------------------------------------
module doodle_plat_scan
   import doodle_pkg::*;
#(
   parameter int NUM_PLAT = DEF_NUM_PLAT,
   parameter int COORD_W  = DEF_COORD_W,
   parameter int DOODLE_R = DEF_DOODLE_R,
   parameter int PLAT_W   = DEF_PLAT_W,
   parameter int PLAT_H   = DEF_PLAT_H
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          start,
   input  logic [NUM_PLAT*COORD_W-1:0]   plat_x,
   input  logic [NUM_PLAT*COORD_W-1:0]   plat_y,
   input  logic [COORD_W-1:0]            doodle_x,
   input  logic [COORD_W-1:0]            doodle_y,
   input  logic [COORD_W-1:0]            scroll,
   output logic                          hit_now,
   output logic                          miss_done,
   output logic                          hit_valid,
   output logic [$clog2(NUM_PLAT)-1:0]   hit_idx,
   output logic                          busy
);

   localparam int IDX_W = $clog2(NUM_PLAT);
   localparam int W2    = COORD_W + 2;

   logic [COORD_W-1:0] px [NUM_PLAT];
   logic [COORD_W-1:0] py [NUM_PLAT];
   logic [IDX_W-1:0]   idx;
   logic [W2-1:0]      dx, dy, x_lo, x_hi, y_lo, y_hi;
   logic               last;

   generate
      for (genvar i = 0; i < NUM_PLAT; i++) begin : g_plat
         assign px[i] = plat_x[i*COORD_W +: COORD_W];
         assign py[i] = plat_y[i*COORD_W +: COORD_W];
      end
   endgenerate

   // Widened by two bits so bottom/right edges near the top of the range cannot wrap.
   always_comb begin
      dx   = W2'(doodle_x) + W2'(DOODLE_R);
      dy   = W2'(doodle_y) + W2'(DOODLE_R);
      x_lo = W2'(px[idx]);
      x_hi = x_lo + W2'(PLAT_W);
      y_lo = W2'(py[idx]) + W2'(scroll);
      y_hi = y_lo + W2'(PLAT_H);
   end

   assign hit_now   = busy && (dx >= x_lo) && (dx <= x_hi) && (dy >= y_lo) && (dy <= y_hi);
   assign last      = (idx == IDX_W'(NUM_PLAT - 1));
   assign miss_done = busy && last && !hit_now;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         busy      <= 1'b0;
         idx       <= '0;
         hit_valid <= 1'b0;
         hit_idx   <= '0;
      end else begin
         hit_valid <= hit_now;
         if (hit_now) begin
            hit_idx <= idx;
            busy    <= 1'b0;
            idx     <= '0;
         end else if (busy) begin
            if (last) begin
               busy <= 1'b0;
               idx  <= '0;
            end else begin
               idx <= idx + 1'b1;
            end
         end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/doodle_jump_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doodle_jump_ctrl : jump/fall game FSM, score and platform landing control
// Option: DOODLE_SCROLL_EN enables the screen scroll register.  Revision 1.0
// ---------------------------------------------------------------------------
module doodle_jump_ctrl
   import doodle_pkg::*;
#(
   parameter int NUM_PLAT = DEF_NUM_PLAT,
   parameter int COORD_W  = DEF_COORD_W,
   parameter int SCORE_W  = DEF_SCORE_W,
   parameter int DOODLE_R = DEF_DOODLE_R,
   parameter int PLAT_W   = DEF_PLAT_W,
   parameter int PLAT_H   = DEF_PLAT_H,
   parameter int FLOOR_Y  = DEF_FLOOR_Y,
   parameter int V_MIDDLE = DEF_V_MIDDLE
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic                          Start,
   input  logic                          Ack,
   input  logic                          frame_tick,
   input  logic [COORD_W-1:0]            jump_height,
   input  logic [COORD_W-1:0]            up_count,
   input  logic [COORD_W-1:0]            doodle_x,
   input  logic [COORD_W-1:0]            doodle_y,
   input  logic [NUM_PLAT*COORD_W-1:0]   plat_x,
   input  logic [NUM_PLAT*COORD_W-1:0]   plat_y,
   output logic                          q_I,
   output logic                          q_Up,
   output logic                          q_Down,
   output logic                          q_Done,
   output logic [SCORE_W-1:0]            score,
   output logic [COORD_W-1:0]            scroll,
   output logic                          hit_valid,
   output logic [$clog2(NUM_PLAT)-1:0]   hit_idx,
   output logic                          scan_busy
);

   localparam int W2 = COORD_W + 2;

   state_t        state, state_nxt;
   logic          up_done, over_floor, hit_now, miss_done, scan_start;
   logic [W2-1:0] feet_y;

   assign up_done    = (up_count >= jump_height);
   assign feet_y     = W2'(doodle_y) + W2'(DOODLE_R);
   assign over_floor = (feet_y > W2'(FLOOR_Y));
   assign scan_start = (state == ST_DOWN) && frame_tick && !scan_busy;

   assign q_I    = state[0];
   assign q_Up   = state[1];
   assign q_Down = state[2];
   assign q_Done = state[3];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= ST_I;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_I:    if (Start)   state_nxt = ST_UP;
         ST_UP:   if (up_done) state_nxt = ST_DOWN;
         ST_DOWN: begin
            if (hit_now)                      state_nxt = ST_UP;
            else if (miss_done && over_floor) state_nxt = ST_DONE;
         end
         ST_DONE: if (Ack)     state_nxt = ST_I;
         default:              state_nxt = ST_I;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         score <= '0;
      else if (state == ST_I)
         score <= '0;
      else if ((state == ST_UP) && frame_tick && !up_done && (score != '1))
         score <= score + 1'b1;
   end

`ifdef DOODLE_SCROLL_EN
   logic [COORD_W-1:0] scroll_r;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         scroll_r <= '0;
      else if (state == ST_I)
         scroll_r <= '0;
      else if ((state == ST_UP) && frame_tick && (doodle_y <= COORD_W'(V_MIDDLE)) && (scroll_r != '1))
         scroll_r <= scroll_r + 1'b1;
   end

   assign scroll = scroll_r;
`else
   assign scroll = '0;
`endif

   doodle_plat_scan #(
      .NUM_PLAT (NUM_PLAT),
      .COORD_W  (COORD_W),
      .DOODLE_R (DOODLE_R),
      .PLAT_W   (PLAT_W),
      .PLAT_H   (PLAT_H)
   ) u_scan (
      .Clk       (Clk),
      .Reset     (Reset),
      .start     (scan_start),
      .plat_x    (plat_x),
      .plat_y    (plat_y),
      .doodle_x  (doodle_x),
      .doodle_y  (doodle_y),
      .scroll    (scroll),
      .hit_now   (hit_now),
      .miss_done (miss_done),
      .hit_valid (hit_valid),
      .hit_idx   (hit_idx),
      .busy      (scan_busy)
   );

endmodule
`default_nettype wire

// File: tb/tb_doodle_jump_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_doodle_jump_ctrl : directed self-checking bench for doodle_jump_ctrl
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_doodle_jump_ctrl;

   localparam int NUM_PLAT = 6;
   localparam int COORD_W  = 10;
   localparam int SCORE_W  = 16;

   logic                        Clk = 1'b0;
   logic                        Reset, Start, Ack, frame_tick;
   logic [COORD_W-1:0]          jump_height, up_count, doodle_x, doodle_y;
   logic [NUM_PLAT*COORD_W-1:0] plat_x, plat_y;
   logic                        q_I, q_Up, q_Down, q_Done;
   logic [SCORE_W-1:0]          score;
   logic [COORD_W-1:0]          scroll;
   logic                        hit_valid;
   logic [2:0]                  hit_idx;
   logic                        scan_busy;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int n;
   int exp_scroll3, exp_scroll5;

   always #5 Clk = ~Clk;

   doodle_jump_ctrl dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .frame_tick(frame_tick),
      .jump_height(jump_height), .up_count(up_count),
      .doodle_x(doodle_x), .doodle_y(doodle_y), .plat_x(plat_x), .plat_y(plat_y),
      .q_I(q_I), .q_Up(q_Up), .q_Down(q_Down), .q_Done(q_Done),
      .score(score), .scroll(scroll), .hit_valid(hit_valid), .hit_idx(hit_idx),
      .scan_busy(scan_busy)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
   endtask

   task automatic set_plat(input int i, input int x, input int y);
      plat_x[i*COORD_W +: COORD_W] = COORD_W'(x);
      plat_y[i*COORD_W +: COORD_W] = COORD_W'(y);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef DOODLE_SCROLL_EN
      exp_scroll3 = 3;
      exp_scroll5 = 5;
`else
      exp_scroll3 = 0;
      exp_scroll5 = 0;
`endif
      Reset = 1'b1; Start = 1'b0; Ack = 1'b0; frame_tick = 1'b0;
      jump_height = 10'd100; up_count = 10'd0;
      doodle_x = 10'd300; doodle_y = 10'd200;
      for (int i = 0; i < NUM_PLAT; i++) set_plat(i, 600, 600);
      tick(); tick();

      check("rst_q_I", q_I, 1);
      check("rst_q_Up", q_Up, 0);
      check("rst_score", score, 0);
      check("rst_scroll", scroll, 0);
      check("rst_hit_valid", hit_valid, 0);
      check("rst_hit_idx", hit_idx, 0);
      check("rst_scan_busy", scan_busy, 0);

      Reset = 1'b0;
      tick();
      Start = 1'b1; Ack = 1'b1;
      tick();
      Start = 1'b0; Ack = 1'b0;
      check("start_over_ack_q_Up", q_Up, 1);
      check("score_at_up", score, 0);

      for (int k = 1; k <= 5; k++) begin
         frame();
         if (k == 3) check("scroll_after_3", scroll, exp_scroll3);
      end
      check("up_q_Up", q_Up, 1);
      check("score_5", score, 5);

      up_count = 10'd100;
      tick();
      check("to_down_q_Down", q_Down, 1);
      check("score_frozen", score, 5);

      // landing on platform 2, later than platforms 0 and 1
      doodle_y = 10'd190;
      set_plat(2, 256, 200 - exp_scroll5);
      exp_q.push_back(2);
      frame();
      check("scan_started", scan_busy, 1);
      n = 1;
      while (!hit_valid && n < 12) begin
         tick();
         n++;
      end
      check("hit_valid", hit_valid, 1);
      check("hit_idx", hit_idx, exp_q.pop_front());
      check("hit_scan_cycle", n, 4);
      check("hit_q_Up", q_Up, 1);
      check("hit_scan_busy", scan_busy, 0);
      tick();
      check("hit_pulse_one_cycle", hit_valid, 0);
      check("hit_idx_hold", hit_idx, 2);
      check("back_to_down", q_Down, 1);
      check("score_after_hit", score, 5);

      // feet exactly on the floor: a miss keeps falling
      set_plat(2, 600, 600);
      doodle_y = 10'd505;
      frame();
      repeat (6) tick();
      check("floor_edge_q_Down", q_Down, 1);
      check("floor_edge_busy", scan_busy, 0);

      doodle_y = 10'd510;
      frame();
      repeat (5) tick();
      check("miss_scan_busy", scan_busy, 1);
      check("miss_still_down", q_Down, 1);
      tick();
      check("miss_q_Done", q_Done, 1);
      check("miss_busy_clear", scan_busy, 0);

      Start = 1'b1;
      tick();
      Start = 1'b0;
      check("done_ignores_start", q_Done, 1);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      check("ack_q_I", q_I, 1);
      tick();
      check("score_clear_in_I", score, 0);

      // asynchronous reset in the middle of a scan
      Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      check("rescan_q_Down", q_Down, 1);
      doodle_y = 10'd100;
      frame();
      tick(); tick();
      check("midscan_busy", scan_busy, 1);
      #2 Reset = 1'b1;
      #1;
      check("async_q_I", q_I, 1);
      check("async_q_Down", q_Down, 0);
      check("async_busy", scan_busy, 0);
      check("async_hit_idx", hit_idx, 0);
      check("async_hit_valid", hit_valid, 0);
      check("async_score", score, 0);
      #3 Reset = 1'b0;
      tick();
      frame();
      check("no_scan_in_I", scan_busy, 0);
      check("stay_I", q_I, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/doodle_jump_ctrl.md
DOODLE_JUMP_CTRL -- requirements
Module: doodle_jump_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLAT, default 6, number of platforms.
REQ-002 SHALL have parameter COORD_W, default 10, coordinate width.
REQ-003 SHALL have parameter SCORE_W, default 16, score width.
REQ-004 SHALL have parameters DOODLE_R=10, PLAT_W=64, PLAT_H=16, FLOOR_Y=515, V_MIDDLE=275: geometry in screen pixels.
REQ-005 SHALL have Clk input 1: clock.
REQ-006 SHALL have Reset input 1: reset Reset, asynchronous, active-high.
REQ-007 SHALL have Start, Ack, frame_tick inputs 1 each: game start, game-over acknowledge, one-cycle frame strobe.
REQ-008 SHALL have jump_height and up_count inputs COORD_W each: jump limit and current jump distance.
REQ-009 SHALL have doodle_x and doodle_y inputs COORD_W each: doodle centre.
REQ-010 SHALL have plat_x and plat_y inputs NUM_PLAT*COORD_W each: flattened platform top-left corners, index 0 in LSBs.
REQ-011 SHALL have q_I, q_Up, q_Down, q_Done outputs 1 each: one-hot state.
REQ-012 SHALL have score output SCORE_W, scroll output COORD_W, hit_valid output 1, hit_idx output $clog2(NUM_PLAT), scan_busy output 1.

Function
REQ-013 SHALL implement states I, UP, DOWN, DONE, one-hot; any illegal encoding SHALL go to I next cycle.
REQ-014 I: Start=1 -> UP next cycle; score and scroll cleared to 0 while in I.
REQ-015 UP: up_count >= jump_height -> DOWN next cycle; otherwise score +1 per frame_tick, saturating at 2^SCORE_W-1.
REQ-016 DOWN: frame_tick with scan idle SHALL start a scan at index 0 and assert scan_busy; the scan tests one platform per cycle; frame_tick during a scan is ignored.
REQ-017 A hit SHALL require doodle_x+DOODLE_R in [px, px+PLAT_W] and doodle_y+DOODLE_R in [py+scroll, py+scroll+PLAT_H], inclusive, computed in COORD_W+2 bits with no wrap.
REQ-018 On the first hit: abort the scan, pulse hit_valid for one cycle with hit_idx = platform index, and go to UP on the same edge.
REQ-019 Scan ending after NUM_PLAT cycles with no hit: if doodle_y+DOODLE_R > FLOOR_Y -> DONE, else stay in DOWN; scan_busy deasserts.
REQ-020 DONE: Ack=1 -> I next cycle; Start is ignored in DONE.
REQ-021 Start and Ack asserted together in I SHALL take Start.
REQ-022 hit_idx SHALL hold its last value when hit_valid=0.

Reset
REQ-023 Reset SHALL force state I, score=0, scroll=0, hit_valid=0, hit_idx=0, scan_busy=0, and scan index 0, mid-scan included; no output is X.

Configuration
REQ-024 Macro DOODLE_SCROLL_EN defined: in UP, when doodle_y <= V_MIDDLE, scroll +1 per frame_tick, saturating at 2^COORD_W-1; value held in DOWN and DONE.
REQ-025 DOODLE_SCROLL_EN undefined: scroll is constant 0 and no scroll register is synthesised.

Structure
REQ-026 Package doodle_pkg SHALL hold state encodings and default geometry constants.
REQ-027 Scan counter and hit comparator SHALL be sub-module doodle_plat_scan, instantiated once.

Verification
REQ-028 Reset, then Start, up_count=0, jump_height=100, 5 frame_ticks -> q_Up=1, score=5.
REQ-029 up_count=100 -> DOWN next cycle; score frozen at 5.
REQ-030 DOWN, doodle=(300,190), plat2=(256,200), scroll=0, frame_tick -> hit_valid pulse at scan cycle 3, hit_idx=2, q_Up=1.
REQ-031 DOWN, no platform overlap, doodle_y=510, one full 6-cycle scan -> q_Done=1; Ack -> q_I=1.
REQ-032 Reset asserted at scan cycle 3 -> all outputs at reset values at once; next frame_tick without Start starts no scan.
REQ-033 DOODLE_SCROLL_EN defined, UP, doodle_y=200, 3 frame_ticks -> scroll=3; undefined -> scroll=0.
